// File: rtl/conv33_output_arbiter.sv
// Round-robin arbiter that merges NUM_CH first-word-fall-through conv33 output
// buffers into one registered, channel-tagged output stream, framed by FRAME_LEN words per channel.
module conv33_output_arbiter #(
  parameter int OUT_WIDTH = 8,
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 16,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_CH-1:0]           ch_valid,
  input  logic [NUM_CH*OUT_WIDTH-1:0] ch_data,
  output logic [NUM_CH-1:0]           ch_read_en,
  output logic                        out_valid,
  output logic [OUT_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]             out_ch,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        frame_done
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                 state_reg, state_next;
  logic [15:0]            cnt_reg [NUM_CH];
  logic [CH_W-1:0]        ptr_reg;
  logic [CH_W-1:0]        ptr_next;
  logic [NUM_CH-1:0]      eligible;
  logic [OUT_WIDTH-1:0]   ch_word [NUM_CH];
  logic                   any_eligible;
  logic [CH_W-1:0]        grant;
  logic                   load;
  logic                   accept;
  logic                   final_pop;
  logic                   all_full_after;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign eligible[gi]   = ch_valid[gi] && (cnt_reg[gi] < 16'(FRAME_LEN));
      assign ch_word[gi]    = ch_data[gi*OUT_WIDTH +: OUT_WIDTH];
      assign ch_read_en[gi] = load && (grant == CH_W'(gi));
    end
  endgenerate

  // Scan from the farthest offset back towards ptr so the closest eligible channel wins.
  always_comb begin
    int sum;
    logic [CH_W-1:0] idx;
    grant        = '0;
    any_eligible = 1'b0;
    sum          = 0;
    idx          = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      sum = int'(ptr_reg) + k;
      if (sum >= NUM_CH) sum = sum - NUM_CH;
      idx = CH_W'(sum);
      if (eligible[idx]) begin
        grant        = idx;
        any_eligible = 1'b1;
      end
    end
  end

  assign accept     = out_valid && out_ready;
  assign load       = !rst && (state_reg == RUN) && (!out_valid || out_ready) && any_eligible;
  assign busy       = (state_reg != IDLE);
  // In FLUSH no further loads happen, so the held word is the frame's last one.
  assign frame_done = !rst && (state_reg == FLUSH) && accept && out_last;
  assign ptr_next   = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);

  // The final pop is the one after which every channel count reaches FRAME_LEN.
  always_comb begin
    logic [16:0] cnt_after;
    all_full_after = 1'b1;
    cnt_after      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_after = {1'b0, cnt_reg[i]} + (ch_read_en[i] ? 17'd1 : 17'd0);
      if (cnt_after != 17'(FRAME_LEN)) all_full_after = 1'b0;
    end
    final_pop = load && all_full_after;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (final_pop) state_next = FLUSH;
      FLUSH:   if (frame_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        out_data  <= ch_word[grant];
        out_ch    <= grant;
        out_valid <= 1'b1;
        out_last  <= final_pop;
        ptr_reg   <= ptr_next;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst || (state_reg == IDLE && start)) begin
        cnt_reg[i] <= '0;
      end else if (ch_read_en[i]) begin
        cnt_reg[i] <= cnt_reg[i] + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_conv33_output_arbiter.sv
// Directed testbench for conv33_output_arbiter with NUM_CH=4, FRAME_LEN=4.
module tb_conv33_output_arbiter;

  localparam int NCH = 4;
  localparam int FL  = 4;
  localparam int OW  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             out_ready = 1'b1;
  logic             buf_clr = 1'b0;
  logic [NCH-1:0]   ch_valid = '1;
  logic [NCH*OW-1:0] ch_data;
  logic [NCH-1:0]   ch_read_en;
  logic             out_valid;
  logic [OW-1:0]    out_data;
  logic [1:0]       out_ch;
  logic             out_last;
  logic             busy;
  logic             frame_done;

  logic [7:0]       popped [NCH];
  logic [10:0]      w_word [64];
  int               w_cyc [64];
  int               cyc = 0;
  int               start_cyc;
  int               n_words, done_cnt, done_word, multi_pop;
  int               errors = 0;
  int               checks = 0;

  always #5 clk = ~clk;

  conv33_output_arbiter #(.OUT_WIDTH(OW), .NUM_CH(NCH), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_read_en(ch_read_en), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_last(out_last), .out_ready(out_ready), .busy(busy), .frame_done(frame_done)
  );

  // Buffer model: channel i presents {i, number of words popped so far}.
  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_buf
      assign ch_data[gi*OW +: OW] = {4'(gi), popped[gi][3:0]};
    end
  endgenerate

  always @(posedge clk) begin
    for (int i = 0; i < NCH; i++) begin
      if (rst || buf_clr) popped[i] <= 8'd0;
      else if (ch_read_en[i]) popped[i] <= popped[i] + 8'd1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic sample();
    #1;
    if (out_valid && out_ready && n_words < 64) begin
      w_word[n_words] = {out_ch, out_data, out_last};
      w_cyc[n_words]  = cyc;
      n_words++;
    end
    if (frame_done) begin
      done_cnt++;
      done_word = n_words;
    end
    if ($countones(ch_read_en) > 1) multi_pop++;
  endtask

  task automatic begin_frame();
    n_words = 0; done_cnt = 0; done_word = -1; multi_pop = 0;
    for (int i = 0; i < 64; i++) w_word[i] = 'x;
    step();
    buf_clr = 1'b1;
    step();
    buf_clr = 1'b0;
    start = 1'b1;
    start_cyc = cyc;
    sample();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_ch, out_last, busy, frame_done, ch_read_en} !== '0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b data=%h ch=%0d last=%b busy=%b done=%b rd=%b required all zero",
               out_valid, out_data, out_ch, out_last, busy, frame_done, ch_read_en);
    end
  endtask

  task automatic test_full_frame();
    logic [10:0] exp;
    ch_valid = 4'b1111;
    out_ready = 1'b1;
    begin_frame();
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      step();
      start = 1'b0;
      sample();
    end
    for (int i = 0; i < 16; i++) begin
      exp = {2'(i % 4), 8'((i % 4) * 16 + i / 4), 1'(i == 15)};
      checks++;
      if (w_word[i] !== exp) begin
        errors++;
        $display("FAIL full_word%0d: got ch/data/last=%h required %h", i, w_word[i], exp);
      end
    end
    checks++;
    if (w_cyc[0] - start_cyc != 2 || w_cyc[15] - w_cyc[0] != 15) begin
      errors++;
      $display("FAIL full_timing: got first at +%0d span %0d required +2 span 15",
               w_cyc[0] - start_cyc, w_cyc[15] - w_cyc[0]);
    end
    checks++;
    if (done_cnt != 1 || done_word != 16) begin
      errors++;
      $display("FAIL full_done: got %0d pulses at word %0d required 1 at word 16", done_cnt, done_word);
    end
    step();
    sample();
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || n_words != 16) begin
      errors++;
      $display("FAIL full_after: got busy=%b valid=%b words=%0d required 0 0 16", busy, out_valid, n_words);
    end
  endtask

  task automatic test_stall();
    logic [10:0] exp;
    int stall_cnt = 0;
    bit  resumed = 0;
    ch_valid = 4'b1111;
    begin_frame();
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      step();
      start = 1'b0;
      if (n_words == 3 && stall_cnt < 5) begin
        out_ready = 1'b0;
        stall_cnt++;
      end else begin
        out_ready = 1'b1;
      end
      sample();
      if (!out_ready) begin
        checks++;
        if ({out_valid, ch_read_en, out_ch, out_data} !== {1'b1, 4'b0000, 2'd3, 8'h30}) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b rd=%b ch=%0d data=%h required 1 0000 3 30",
                   out_valid, ch_read_en, out_ch, out_data);
        end
      end else if (stall_cnt == 5 && !resumed) begin
        resumed = 1;
        checks++;
        if (ch_read_en !== 4'b0001) begin
          errors++;
          $display("FAIL stall_resume: got rd=%b required 0001", ch_read_en);
        end
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp = {2'(i % 4), 8'((i % 4) * 16 + i / 4), 1'(i == 15)};
      checks++;
      if (w_word[i] !== exp) begin
        errors++;
        $display("FAIL stall_word%0d: got ch/data/last=%h required %h", i, w_word[i], exp);
      end
    end
    checks++;
    if (done_cnt != 1 || stall_cnt != 5) begin
      errors++;
      $display("FAIL stall_done: got %0d pulses, %0d stall cycles required 1 and 5", done_cnt, stall_cnt);
    end
  endtask

  task automatic test_single_channel();
    int seq [16] = '{2, 2, 2, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 3, 0, 1};
    int occ [4] = '{0, 0, 0, 0};
    int masked_pops = 0;
    logic [10:0] exp;
    ch_valid = 4'b0100;
    begin_frame();
    for (int c = 0; c < 80 && done_cnt == 0; c++) begin
      step();
      start = 1'b0;
      ch_valid = (c < 10) ? 4'b0100 : 4'b1111;
      sample();
      if (c >= 4 && c < 10 && ch_read_en !== 4'b0000) masked_pops++;
    end
    for (int i = 0; i < 16; i++) begin
      exp = {2'(seq[i]), 8'(seq[i] * 16 + occ[seq[i]]), 1'(i == 15)};
      occ[seq[i]]++;
      checks++;
      if (w_word[i] !== exp) begin
        errors++;
        $display("FAIL single_word%0d: got ch/data/last=%h required %h", i, w_word[i], exp);
      end
    end
    checks++;
    if (masked_pops != 0 || done_cnt != 1 || multi_pop != 0) begin
      errors++;
      $display("FAIL single_mask: got %0d masked pops, %0d done, %0d multi required 0 1 0",
               masked_pops, done_cnt, multi_pop);
    end
  endtask

  task automatic test_sparse();
    int seq [16] = '{2, 3, 1, 3, 1, 3, 1, 3, 1, 2, 0, 2, 0, 2, 0, 0};
    int occ [4] = '{0, 0, 0, 0};
    logic [3:0] bad_pop = '0;
    int pops;
    logic [10:0] exp;
    ch_valid = 4'b0100;
    begin_frame();
    for (int c = 0; c < 80 && done_cnt == 0; c++) begin
      step();
      start = 1'b0;
      pops = popped[0] + popped[1] + popped[2] + popped[3];
      ch_valid = (pops == 0) ? 4'b0100 : (pops < 9) ? 4'b1010 : 4'b1111;
      sample();
      if (ch_valid == 4'b1010) bad_pop |= ch_read_en & 4'b0101;
    end
    for (int i = 0; i < 16; i++) begin
      exp = {2'(seq[i]), 8'(seq[i] * 16 + occ[seq[i]]), 1'(i == 15)};
      occ[seq[i]]++;
      checks++;
      if (w_word[i] !== exp) begin
        errors++;
        $display("FAIL sparse_word%0d: got ch/data/last=%h required %h", i, w_word[i], exp);
      end
    end
    checks++;
    if (bad_pop !== 4'b0000 || multi_pop != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL sparse_pops: got ch0/ch2 pops=%b multi=%0d done=%0d required 0000 0 1",
               bad_pop, multi_pop, done_cnt);
    end
  endtask

  task automatic test_mid_reset();
    logic [10:0] exp;
    ch_valid = 4'b1111;
    begin_frame();
    for (int c = 0; c < 30 && n_words < 6; c++) begin
      step();
      start = 1'b0;
      sample();
    end
    step();
    rst = 1'b1;
    #1;
    checks++;
    if (ch_read_en !== 4'b0000) begin
      errors++;
      $display("FAIL reset_nopop: got rd=%b required 0000", ch_read_en);
    end
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_ch, out_last, busy, frame_done, ch_read_en} !== '0) begin
      errors++;
      $display("FAIL midreset_state: got valid=%b data=%h ch=%0d last=%b busy=%b done=%b rd=%b required all zero",
               out_valid, out_data, out_ch, out_last, busy, frame_done, ch_read_en);
    end
    begin_frame();
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      step();
      start = 1'b0;
      sample();
    end
    for (int i = 0; i < 16; i++) begin
      exp = {2'(i % 4), 8'((i % 4) * 16 + i / 4), 1'(i == 15)};
      checks++;
      if (w_word[i] !== exp) begin
        errors++;
        $display("FAIL midreset_word%0d: got ch/data/last=%h required %h", i, w_word[i], exp);
      end
    end
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL midreset_done: got %0d pulses required 1", done_cnt);
    end
  endtask

  task automatic test_start_during_run();
    logic [10:0] exp;
    ch_valid = 4'b1111;
    begin_frame();
    // start is held high through the whole frame, including the final-accept cycle.
    for (int c = 0; c < 60 && done_cnt == 0; c++) begin
      step();
      sample();
    end
    step();
    start = 1'b0;
    sample();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_at_done: got busy=%b required 0", busy);
    end
    for (int c = 0; c < 8; c++) begin
      step();
      sample();
    end
    for (int i = 0; i < 16; i++) begin
      exp = {2'(i % 4), 8'((i % 4) * 16 + i / 4), 1'(i == 15)};
      checks++;
      if (w_word[i] !== exp) begin
        errors++;
        $display("FAIL startrun_word%0d: got ch/data/last=%h required %h", i, w_word[i], exp);
      end
    end
    checks++;
    if (n_words != 16 || done_cnt != 1) begin
      errors++;
      $display("FAIL startrun_count: got %0d words %0d done required 16 and 1", n_words, done_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_single_channel();
    test_sparse();
    test_mid_reset();
    test_start_during_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
